// File: rtl/furv_lsu_if.sv
// Core-side request/response and data-bus signals of the furv load/store unit.
// The slave modport is the LSU's view; master is the core/bus environment's view.
interface furv_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;

  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic [1:0]        resp_code;

  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [NB-1:0]     bus_be;
  logic [XLEN-1:0]   bus_wdata;
  logic [XLEN-1:0]   bus_rdata;
  logic              bus_err;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err, resp_code,
    output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata, bus_err
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err, resp_code,
    input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata, bus_err
  );
endinterface

// File: rtl/furv_lsu.sv
// Load/store unit: one outstanding access, sized byte-lane bus transfers with
// sign/zero extension, misalignment detection, bus errors and a wait-state timeout.
module furv_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic       clk,
  input logic       rst_n,
  furv_lsu_if.slave lsu
);
  localparam int NB    = XLEN / 8;
  localparam int OFS   = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] CODE_OK    = 2'd0;
  localparam logic [1:0] CODE_ALIGN = 2'd1;
  localparam logic [1:0] CODE_BUS   = 2'd2;
  localparam logic [1:0] CODE_TMO   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic [NB-1:0]     be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [1:0]        code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Doubleword exists only on a 64-bit datapath; everything else must be naturally aligned.
  function automatic logic is_illegal(input logic [2:0] a, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return (XLEN == 32) || (|a);
    endcase
  endfunction

  function automatic logic [NB-1:0] lane_mask(input logic [1:0] size, input logic [OFS-1:0] ofs);
    logic [NB-1:0] m;
    case (size)
      2'd0:    m = NB'(1);
      2'd1:    m = NB'(3);
      2'd2:    m = NB'(15);
      default: m = '1;
    endcase
    return m << ofs;
  endfunction

  // Replicating the right-aligned datum across the bus places it on every aligned lane group.
  function automatic logic [XLEN-1:0] lane_data(input logic [1:0] size, input logic [XLEN-1:0] wd);
    case (size)
      2'd0:    return {NB{wd[7:0]}};
      2'd1:    return {(NB/2){wd[15:0]}};
      2'd2:    return {(NB/4){wd[31:0]}};
      default: return wd;
    endcase
  endfunction

  // Left-justify the field, then shift back arithmetically or logically to extend it.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw,
                                               input logic [OFS-1:0]  ofs,
                                               input logic [1:0]      size,
                                               input logic            uns);
    logic [XLEN-1:0]        sh;
    logic signed [XLEN-1:0] sfield;
    int                     pad;
    pad = XLEN - (8 << size);
    if (pad < 0) pad = 0;
    sh     = raw >> {ofs, 3'b000};
    sh     = sh << pad;
    sfield = $signed(sh) >>> pad;
    return uns ? (sh >> pad) : sfield;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      code_q  <= CODE_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (lsu.req_valid) begin
          addr_d  = lsu.req_addr;
          size_d  = lsu.req_size;
          uns_d   = lsu.req_unsigned;
          we_d    = lsu.req_write;
          be_d    = lane_mask(lsu.req_size, lsu.req_addr[OFS-1:0]);
          wdata_d = lane_data(lsu.req_size, lsu.req_wdata);
          rdata_d = '0;
          cnt_d   = '0;
          if (is_illegal(lsu.req_addr[2:0], lsu.req_size)) begin
            code_d  = CODE_ALIGN;
            state_d = S_RESP;
          end else begin
            code_d  = CODE_OK;
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        // A ready on the final permitted cycle still completes the transfer.
        if (lsu.bus_ready) begin
          state_d = S_RESP;
          if (lsu.bus_err) begin
            code_d = CODE_BUS;
          end else if (!we_q) begin
            rdata_d = load_ext(lsu.bus_rdata, addr_q[OFS-1:0], size_q, uns_q);
          end
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          state_d = S_RESP;
          code_d  = CODE_TMO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        rdata_d = '0;
        code_d  = CODE_OK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign lsu.req_ready  = (state_q == S_IDLE);
  assign lsu.bus_valid  = (state_q == S_BUS);
  assign lsu.bus_we     = we_q;
  assign lsu.bus_addr   = {addr_q[ADDR_W-1:OFS], {OFS{1'b0}}};
  assign lsu.bus_be     = be_q;
  assign lsu.bus_wdata  = wdata_q;
  assign lsu.resp_valid = (state_q == S_RESP);
  assign lsu.resp_rdata = lsu.resp_valid ? rdata_q : '0;
  assign lsu.resp_code  = lsu.resp_valid ? code_q : CODE_OK;
  assign lsu.resp_err   = lsu.resp_valid && (code_q != CODE_OK);

endmodule

// File: tb/tb_furv_lsu.sv
// Bench for furv_lsu: a 32-bit and a 64-bit instance (both TIMEOUT=4) sharing one
// stimulus path, checked against a spec-level access model.
module tb_furv_lsu;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        sel64 = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        bus_ready = 1'b0, bus_err = 1'b0;
  logic [63:0] bus_rdata = '0;

  furv_lsu_if #(.XLEN(32), .ADDR_W(32)) if32 ();
  furv_lsu_if #(.XLEN(64), .ADDR_W(32)) if64 ();

  assign if32.req_valid    = req_valid & ~sel64;
  assign if64.req_valid    = req_valid & sel64;
  assign if32.bus_ready    = bus_ready & ~sel64;
  assign if64.bus_ready    = bus_ready & sel64;
  assign if32.req_write    = req_write;
  assign if64.req_write    = req_write;
  assign if32.req_size     = req_size;
  assign if64.req_size     = req_size;
  assign if32.req_unsigned = req_unsigned;
  assign if64.req_unsigned = req_unsigned;
  assign if32.req_addr     = req_addr;
  assign if64.req_addr     = req_addr;
  assign if32.req_wdata    = req_wdata[31:0];
  assign if64.req_wdata    = req_wdata;
  assign if32.bus_rdata    = bus_rdata[31:0];
  assign if64.bus_rdata    = bus_rdata;
  assign if32.bus_err      = bus_err;
  assign if64.bus_err      = bus_err;

  furv_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut32 (.clk(clk), .rst_n(rst_n), .lsu(if32.slave));
  furv_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TO)) dut64 (.clk(clk), .rst_n(rst_n), .lsu(if64.slave));

  wire        o_req_ready  = sel64 ? if64.req_ready  : if32.req_ready;
  wire        o_resp_valid = sel64 ? if64.resp_valid : if32.resp_valid;
  wire [63:0] o_resp_rdata = sel64 ? if64.resp_rdata : {32'b0, if32.resp_rdata};
  wire        o_resp_err   = sel64 ? if64.resp_err   : if32.resp_err;
  wire [1:0]  o_resp_code  = sel64 ? if64.resp_code  : if32.resp_code;
  wire        o_bus_valid  = sel64 ? if64.bus_valid  : if32.bus_valid;
  wire        o_bus_we     = sel64 ? if64.bus_we     : if32.bus_we;
  wire [31:0] o_bus_addr   = sel64 ? if64.bus_addr   : if32.bus_addr;
  wire [7:0]  o_bus_be     = sel64 ? if64.bus_be     : {4'b0, if32.bus_be};
  wire [63:0] o_bus_wdata  = sel64 ? if64.bus_wdata  : {32'b0, if32.bus_wdata};

  // Value a load should return: pick the addressed bytes, extend to the data width.
  function automatic logic [63:0] model_load(bit w64, logic [1:0] sz, bit uns,
                                             logic [31:0] addr, logic [63:0] rd);
    int nb = 1 << sz;
    int ofs = w64 ? int'(addr[2:0]) : int'(addr[1:0]);
    logic [63:0] mask, v;
    mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v = (w64 ? rd : {32'b0, rd[31:0]}) >> (8 * ofs);
    v = v & mask;
    if (!uns && v[8 * nb - 1]) v = v | ~mask;
    if (!w64) v[63:32] = 32'b0;
    return v;
  endfunction

  task automatic access(input bit w64, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                        input int wait_n, input bit err,
                        output logic [63:0] r, output logic [1:0] c, output int bvc);
    int nbw, ofs, exp_bv, exp_at, nresp, at;
    bit illegal;
    logic e;
    logic [63:0] exp_r;
    logic [1:0] exp_c;
    logic [7:0] exp_be;
    nbw = w64 ? 8 : 4;
    ofs = int'(addr & 32'(nbw - 1));
    illegal = (sz == 2'd3 && !w64) || ((addr & 32'((1 << sz) - 1)) != 0);
    if (illegal) begin
      exp_bv = 0; exp_at = 1; exp_c = 2'd1; exp_r = '0;
    end else if (wait_n >= TO) begin
      exp_bv = TO; exp_at = TO + 1; exp_c = 2'd3; exp_r = '0;
    end else begin
      exp_bv = wait_n + 1; exp_at = wait_n + 2;
      exp_c = err ? 2'd2 : 2'd0;
      exp_r = (err || wr) ? 64'd0 : model_load(w64, sz, uns, addr, rd);
    end
    exp_be = 8'(((1 << (1 << sz)) - 1) << ofs);
    r = '0; c = '0; e = 1'b0; bvc = 0; nresp = 0; at = 0;

    sel64 = w64;
    bus_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    checks++;
    if (o_req_ready !== 1'b1) begin failures++; $display("FAIL accept_ready got=%0b want=1", o_req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = {$urandom, $urandom};
    req_size = 2'($urandom); req_write = 1'($urandom); req_unsigned = 1'($urandom);

    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (o_bus_valid) begin
        bvc++;
        checks++;
        if (o_bus_addr !== (addr & ~32'(nbw - 1)) || o_bus_be !== exp_be || o_bus_we !== wr) begin
          failures++;
          $display("FAIL bus_fields addr=%h be=%b we=%0b want addr=%h be=%b we=%0b",
                   o_bus_addr, o_bus_be, o_bus_we, addr & ~32'(nbw - 1), exp_be, wr);
        end
        if (wr) begin
          for (int i = 0; i < nbw; i++) begin
            if (exp_be[i]) begin
              checks++;
              if (o_bus_wdata[8*i +: 8] !== wd[8*(i-ofs) +: 8]) begin
                failures++;
                $display("FAIL wdata_lane%0d got=%h want=%h", i, o_bus_wdata[8*i +: 8], wd[8*(i-ofs) +: 8]);
              end
            end
          end
        end
        bus_ready = (bvc > wait_n); bus_err = err; bus_rdata = rd;
      end else begin
        bus_ready = 1'b0; bus_err = 1'($urandom); bus_rdata = {$urandom, $urandom};
      end
      if (o_resp_valid) begin
        nresp++; at = k; r = o_resp_rdata; c = o_resp_code; e = o_resp_err;
      end else begin
        checks++;
        if (o_resp_rdata !== 64'd0 || o_resp_code !== 2'd0 || o_resp_err !== 1'b0) begin
          failures++;
          $display("FAIL resp_idle_zero rdata=%h code=%0d err=%0b want 0", o_resp_rdata, o_resp_code, o_resp_err);
        end
      end
      if (nresp > 0 && k > at) begin
        checks++;
        if (o_req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_resp got=%0b want=1", o_req_ready); end
        break;
      end
    end
    bus_ready = 1'b0;

    checks++;
    if (nresp !== 1) begin failures++; $display("FAIL resp_count got=%0d want=1", nresp); end
    checks++;
    if (bvc !== exp_bv) begin failures++; $display("FAIL bus_cycles got=%0d want=%0d", bvc, exp_bv); end
    checks++;
    if (at !== exp_at) begin failures++; $display("FAIL resp_latency got=%0d want=%0d", at, exp_at); end
    checks++;
    if (r !== exp_r || c !== exp_c || e !== (exp_c != 2'd0)) begin
      failures++;
      $display("FAIL resp_data w64=%0b sz=%0d a=%h rdata=%h code=%0d err=%0b want rdata=%h code=%0d",
               w64, sz, addr, r, c, e, exp_r, exp_c);
    end
  endtask

  task automatic check_reset_outputs(input bit w64);
    sel64 = w64; #1;
    checks++;
    if (o_req_ready !== 1'b1 || o_bus_valid !== 1'b0 || o_resp_valid !== 1'b0 ||
        o_bus_addr !== 32'd0 || o_bus_be !== 8'd0 || o_bus_we !== 1'b0 ||
        o_bus_wdata !== 64'd0 || o_resp_rdata !== 64'd0 || o_resp_code !== 2'd0 || o_resp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state w64=%0b ready=%0b bv=%0b rv=%0b addr=%h be=%b want ready=1 rest 0",
               w64, o_req_ready, o_bus_valid, o_resp_valid, o_bus_addr, o_bus_be);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(1'b0);
    check_reset_outputs(1'b1);
    rst_n = 1'b1;
  endtask

  task automatic test_byte_load();
    logic [63:0] r; logic [1:0] c; int bv;
    access(1'b0, 1'b0, 2'd0, 1'b0, 32'h1003, 64'd0, 64'h80AABBCC, 0, 1'b0, r, c, bv);
    checks++;
    if (r !== 64'hFFFFFF80 || c !== 2'd0) begin failures++; $display("FAIL lb_signed got=%h want=ffffff80", r); end
    access(1'b0, 1'b0, 2'd0, 1'b1, 32'h1003, 64'd0, 64'h80AABBCC, 0, 1'b0, r, c, bv);
    checks++;
    if (r !== 64'h00000080 || c !== 2'd0) begin failures++; $display("FAIL lbu got=%h want=80", r); end
  endtask

  task automatic test_store_wait();
    logic [63:0] r; logic [1:0] c; int bv;
    access(1'b0, 1'b1, 2'd1, 1'b0, 32'h2002, 64'hBEEF, 64'h12345678, 3, 1'b0, r, c, bv);
    checks++;
    if (bv !== 4 || r !== 64'd0 || c !== 2'd0) begin
      failures++; $display("FAIL sh_wait bus_cycles=%0d rdata=%h code=%0d want 4/0/0", bv, r, c);
    end
  endtask

  task automatic test_misaligned();
    logic [63:0] r; logic [1:0] c; int bv;
    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h1001, 64'd0, 64'd0, 0, 1'b0, r, c, bv);
    checks++;
    if (bv !== 0 || c !== 2'd1) begin failures++; $display("FAIL lw_misaligned code=%0d bus_cycles=%0d want 1/0", c, bv); end
    access(1'b0, 1'b0, 2'd3, 1'b0, 32'h1000, 64'd0, 64'd0, 0, 1'b0, r, c, bv);
    checks++;
    if (bv !== 0 || c !== 2'd1) begin failures++; $display("FAIL ld_on_32 code=%0d bus_cycles=%0d want 1/0", c, bv); end
  endtask

  task automatic test_timeout();
    logic [63:0] r; logic [1:0] c; int bv;
    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h4000, 64'd0, 64'hCAFEF00D, 50, 1'b0, r, c, bv);
    checks++;
    if (bv !== TO || c !== 2'd3 || r !== 64'd0) begin
      failures++; $display("FAIL timeout bus_cycles=%0d code=%0d want %0d/3", bv, c, TO);
    end
    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h4000, 64'd0, 64'hCAFEF00D, TO - 1, 1'b0, r, c, bv);
    checks++;
    if (bv !== TO || c !== 2'd0 || r !== 64'hCAFEF00D) begin
      failures++; $display("FAIL ready_on_last bus_cycles=%0d code=%0d rdata=%h want %0d/0/cafef00d", bv, c, r, TO);
    end
  endtask

  task automatic test_bus_err_and_abort();
    logic [63:0] r; logic [1:0] c; int bv;
    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h5004, 64'd0, 64'h11223344, 1, 1'b1, r, c, bv);
    checks++;
    if (c !== 2'd2 || r !== 64'd0) begin failures++; $display("FAIL bus_err code=%0d rdata=%h want 2/0", c, r); end

    sel64 = 1'b0; bus_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h3000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_bus_valid !== 1'b1) begin failures++; $display("FAIL abort_in_bus got=%0b want=1", o_bus_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_bus_valid !== 1'b0 || o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_async bv=%0b rv=%0b ready=%0b want 0/0/1", o_bus_valid, o_resp_valid, o_req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (o_resp_valid !== 1'b0 || o_bus_valid !== 1'b0 || o_req_ready !== 1'b1) begin
        failures++;
        $display("FAIL abort_quiet cyc=%0d rv=%0b bv=%0b ready=%0b", k, o_resp_valid, o_bus_valid, o_req_ready);
      end
    end
  endtask

  task automatic test_xlen64();
    logic [63:0] r; logic [1:0] c; int bv;
    access(1'b1, 1'b0, 2'd3, 1'b0, 32'h8, 64'd0, 64'h8123_4567_89AB_CDEF, 0, 1'b0, r, c, bv);
    checks++;
    if (r !== 64'h8123_4567_89AB_CDEF || c !== 2'd0) begin failures++; $display("FAIL ld64 got=%h want=8123456789abcdef", r); end
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'hC, 64'd0, 64'h8000_0001_1234_5678, 0, 1'b0, r, c, bv);
    checks++;
    if (r !== 64'hFFFF_FFFF_8000_0001 || c !== 2'd0) begin failures++; $display("FAIL lw64_hi got=%h want=ffffffff80000001", r); end
    access(1'b1, 1'b1, 2'd3, 1'b0, 32'h10, 64'h0102_0304_0506_0708, 64'd0, 2, 1'b0, r, c, bv);
    checks++;
    if (r !== 64'd0 || c !== 2'd0) begin failures++; $display("FAIL sd64 rdata=%h code=%0d want 0/0", r, c); end
  endtask

  task automatic test_random();
    logic [63:0] r; logic [1:0] c; int bv;
    bit w64, wr, uns, er;
    logic [1:0] sz;
    logic [31:0] a;
    for (int n = 0; n < 150; n++) begin
      w64 = 1'($urandom);
      wr  = 1'($urandom);
      uns = 1'($urandom);
      sz  = 2'($urandom);
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'((1 << sz) - 1);
      er  = ($urandom_range(0, 7) == 0);
      access(w64, wr, sz, uns, a, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 5)), er, r, c, bv);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte_load();
    test_store_wait();
    test_misaligned();
    test_timeout();
    test_bus_err_and_abort();
    test_xlen64();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/furv_lsu.md
Name: furv_lsu

Overview:
Parametrised load/store unit that sits between the furv core's execute stage and a data bus with a valid/ready handshake. It replaces the core's fixed single-cycle, word-only memory path. It adds byte, halfword, word and (XLEN=64) doubleword accesses, byte enables, sign/zero extension, bus wait states, bus errors, misalignment detection and a wait-state timeout. Exactly one access is outstanding at a time.

Parameters:
XLEN, 32, data width; legal values 32 or 64. NB = XLEN/8 byte lanes; OFS = log2(NB) offset bits.
ADDR_W, 32, address width.
TIMEOUT, 255, maximum cycles bus_valid may stay high without bus_ready; 0 disables the timeout.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  core presents an access.
req_ready  out  1  LSU can accept; equals (state==IDLE).
req_write  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (legal only when XLEN=64).
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
req_addr  in  ADDR_W  byte address.
req_wdata  in  XLEN  store data, right-aligned.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
resp_err  out  1  access failed.
resp_code  out  2  0 ok, 1 misaligned/illegal size, 2 bus error, 3 timeout.
bus_valid  out  1  bus request.
bus_ready  in  1  bus completes the request.
bus_we  out  1  write strobe.
bus_addr  out  ADDR_W  req_addr with the low OFS bits cleared.
bus_be  out  NB  byte enables.
bus_wdata  out  XLEN  lane-positioned store data.
bus_rdata  in  XLEN  full-width read data.
bus_err  in  1  error; sampled only with bus_ready.

Behaviour:
- States: IDLE, BUS, RESP. rst_n low forces IDLE immediately. While in reset, all registered outputs are 0 and req_ready is 1 (combinational from IDLE).
- IDLE: an access is accepted on the edge where req_valid && req_ready. The LSU registers addr, size, unsigned, write and offset.
  - Legal access: go to BUS. Misaligned (addr mod 2^size != 0) or size 3 with XLEN=32: go straight to RESP with resp_code 1. No bus cycle occurs.
- BUS: bus_valid=1, and bus_addr, bus_we, bus_be and bus_wdata are held stable until the handshake.
  - bus_be = ((1<<2^size)-1) << offset.
  - bus_wdata = req_wdata byte-replicated or shifted so that each selected lane carries the correct byte; unselected lanes are don't-care, and the bench checks only enabled lanes.
  - The edge with bus_valid && bus_ready completes the transfer and the LSU moves to RESP:
    - bus_err=1 gives code 2 and rdata 0.
    - Otherwise load data is extracted: (bus_rdata >> 8*offset), truncated to 2^size bytes, then extended to XLEN. The top bit of the extracted field is the sign bit unless req_unsigned is set. Stores return rdata 0.
  - Timeout, when TIMEOUT>0: a wait counter is cleared on entry to BUS and incremented on each edge without bus_ready. If the edge is the TIMEOUT-th consecutive cycle without bus_ready, go to RESP with code 3. bus_valid therefore drops after exactly TIMEOUT cycles. A bus_ready arriving on that same edge wins: the transfer completes normally.
- RESP: resp_valid=1 for exactly one cycle with rdata, err and code stable. resp_err = (code!=0). The next state is IDLE. resp_rdata, resp_err and resp_code are zeroed when resp_valid is low.
- Latency: accept at edge N, bus_valid high from cycle N+1. With a zero-wait bus the handshake completes at edge N+1, resp_valid is high during cycle N+2, and req_ready is high again from N+3. Misaligned/illegal accesses give resp_valid during cycle N+1.
- req_valid is ignored outside IDLE; no queuing.
- Reset asserted in BUS or RESP: bus_valid and resp_valid drop asynchronously, no response is ever produced for the aborted access, and the counter clears.
- The block has no x-propagation dependence: all registers have reset values.

Test Plan:
1. XLEN=32, load byte at addr 0x1003, bus_rdata=0x80AABBCC, zero wait, signed -> bus_addr 0x1000, bus_be 4'b1000, resp_rdata 0xFFFFFF80, code 0, resp_valid during cycle N+2. The same access with req_unsigned -> 0x00000080.
2. Store half 0xBEEF at addr 0x2002, bus_ready delayed 3 cycles -> bus_valid high 4 cycles with stable addr 0x2000, be 4'b1100, wdata[31:16]=0xBEEF; one resp_valid, rdata 0, code 0.
3. Load word at 0x1001, and size 3 with XLEN=32 -> no bus_valid; resp_valid during cycle N+1, resp_err 1, code 1.
4. TIMEOUT=4, bus_ready held low -> bus_valid high exactly 4 cycles, then resp code 3. Repeat with bus_ready asserted on the 4th cycle -> completes with code 0.
5. bus_ready with bus_err=1 on a load -> code 2, rdata 0. Then rst_n pulsed low mid-BUS on a new access -> bus_valid drops at once, no resp_valid, req_ready 1 after release.
6. XLEN=64, signed doubleword load at 0x8 -> be 8'hFF, full 64-bit data returned. Signed word load at 0xC with bus_rdata[63:32]=0x80000001 -> 0xFFFFFFFF80000001.
